// File: rtl/accumulator_mc.sv
// Multi-channel signed accumulator: one registered add/sub/load/clear update per valid sample.
// Optional build macro ACC_SAT_EN adds saturation on overflow and the ovf_o flag.
module accumulator_mc #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned ACC_W  = 38,
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] A,
    input  logic [CH_W-1:0]   ch_i,
    input  logic              subtract_i,
    input  logic              load_i,
    input  logic              clear_i,
    output logic [ACC_W-1:0]  P,
    output logic [CH_W-1:0]   ch_o,
    output logic              valid_o
`ifdef ACC_SAT_EN
    ,
    output logic              ovf_o
`endif
);

    localparam logic [CH_W:0] NumChLim = (CH_W + 1)'(NUM_CH);

    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [ACC_W-1:0] acc_cur;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] arith;
    logic [ACC_W-1:0] acc_new;
    logic             upd;
    logic             ovf_upd;

    assign a_ext = {{(ACC_W - DATA_W){A[DATA_W-1]}}, A};
    assign upd   = valid_i && ({1'b0, ch_i} < NumChLim);

    // Mux by comparison so an out-of-range select never indexes past the array.
    always_comb begin
        acc_cur = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ch_i == CH_W'(i)) begin
                acc_cur = acc_q[i];
            end
        end
    end

`ifdef ACC_SAT_EN
    logic [ACC_W:0] sum;
    logic           ovf;

    always_comb begin
        sum = subtract_i ? {acc_cur[ACC_W-1], acc_cur} - {a_ext[ACC_W-1], a_ext}
                         : {acc_cur[ACC_W-1], acc_cur} + {a_ext[ACC_W-1], a_ext};
        ovf = sum[ACC_W] ^ sum[ACC_W-1];
        if (!ovf) begin
            arith = sum[ACC_W-1:0];
        end else if (sum[ACC_W]) begin
            arith = {1'b1, {(ACC_W - 1){1'b0}}};
        end else begin
            arith = {1'b0, {(ACC_W - 1){1'b1}}};
        end
        ovf_upd = ovf && !clear_i && !load_i;
    end
`else
    always_comb begin
        arith   = subtract_i ? acc_cur - a_ext : acc_cur + a_ext;
        ovf_upd = 1'b0;
    end
`endif

    always_comb begin
        if (clear_i) begin
            acc_new = '0;
        end else if (load_i) begin
            acc_new = a_ext;
        end else begin
            acc_new = arith;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc_q[i] <= '0;
            end
            P       <= '0;
            ch_o    <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= upd;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (upd && ch_i == CH_W'(i)) begin
                    acc_q[i] <= acc_new;
                end
            end
            if (upd) begin
                P    <= acc_new;
                ch_o <= ch_i;
            end
        end
    end

`ifdef ACC_SAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_o <= 1'b0;
        end else begin
            ovf_o <= upd && ovf_upd;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf_upd;
`endif

endmodule

// File: tb/tb_accumulator_mc.sv
// Self-checking bench for accumulator_mc: directed vector table, overflow/range corner
// sequences on a wide-input instance, async reset, and a random run against a model.
module tb_accumulator_mc;

`ifdef ACC_SAT_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic        clk;
    logic        reset;

    logic        v1, sub1, ld1, clr1;
    logic [1:0]  ch1;
    logic [19:0] a1;
    logic [37:0] p1;
    logic [1:0]  cho1;
    logic        vo1;

    logic        v2, sub2, ld2, clr2;
    logic [2:0]  ch2;
    logic [35:0] a2;
    logic [37:0] p2;
    logic [2:0]  cho2;
    logic        vo2;

    logic        ovf1, ovf2;

    int n_checks = 0;
    int n_fail   = 0;

    accumulator_mc u_dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (v1),
        .A          (a1),
        .ch_i       (ch1),
        .subtract_i (sub1),
        .load_i     (ld1),
        .clear_i    (clr1),
        .P          (p1),
        .ch_o       (cho1),
        .valid_o    (vo1)
`ifdef ACC_SAT_EN
        ,
        .ovf_o      (ovf1)
`endif
    );

    // Wide input lets the 38-bit accumulator reach its limits in a handful of cycles.
    accumulator_mc #(
        .DATA_W (36),
        .ACC_W  (38),
        .NUM_CH (5)
    ) u_wide (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (v2),
        .A          (a2),
        .ch_i       (ch2),
        .subtract_i (sub2),
        .load_i     (ld2),
        .clear_i    (clr2),
        .P          (p2),
        .ch_o       (cho2),
        .valid_o    (vo2)
`ifdef ACC_SAT_EN
        ,
        .ovf_o      (ovf2)
`endif
    );

`ifndef ACC_SAT_EN
    assign ovf1 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  ch;
        logic [19:0] a;
        logic        sub;
        logic        ld;
        logic        clr;
        longint      ep;
        logic [1:0]  ech;
        logic        ev;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive1(input logic v, input logic [1:0] ch, input logic [19:0] a,
                          input logic sub, input logic ld, input logic clr);
        v1 = v; ch1 = ch; a1 = a; sub1 = sub; ld1 = ld; clr1 = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input string name, input logic v, input logic [2:0] ch,
                         input logic [35:0] a, input logic sub, input logic ld,
                         input logic clr, input longint ep, input longint ech,
                         input logic ev, input logic eovf);
        v2 = v; ch2 = ch; a2 = a; sub2 = sub; ld2 = ld; clr2 = clr;
        @(posedge clk);
        #1;
        check({name, " P"}, longint'($signed(p2)), ep);
        check({name, " ch_o"}, longint'(cho2), ech);
        check({name, " valid_o"}, longint'(vo2), longint'(ev));
        if (Sat) check({name, " ovf_o"}, longint'(ovf2), longint'(eovf));
    endtask

    // Reference update at arbitrary width using plain integer arithmetic.
    function automatic longint model_upd(input longint acc, input longint a, input bit sub,
                                         input bit ld, input bit clr, input int w,
                                         output bit ovf);
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint mn = -(longint'(1) <<< (w - 1));
        longint r;
        ovf = 1'b0;
        if (clr) r = 0;
        else if (ld) r = a;
        else begin
            r = sub ? acc - a : acc + a;
            if (r > mx || r < mn) begin
                if (Sat) begin
                    ovf = 1'b1;
                    r = (r > mx) ? mx : mn;
                end else begin
                    r = (r > mx) ? r - (longint'(1) <<< w) : r + (longint'(1) <<< w);
                end
            end
        end
        return r;
    endfunction

    initial begin
        longint macc [4];
        longint p_m, ch_m;
        bit     v_m, ovf_m, o;

        vecs = '{
            '{1'b1, 2'd0, 20'hFFFFF, 1'b0, 1'b0, 1'b0, -1,       2'd0, 1'b1},
            '{1'b1, 2'd0, 20'hFFFFF, 1'b0, 1'b0, 1'b0, -2,       2'd0, 1'b1},
            '{1'b1, 2'd0, 20'hFFFFF, 1'b0, 1'b0, 1'b0, -3,       2'd0, 1'b1},
            '{1'b1, 2'd1, 20'd100,   1'b0, 1'b1, 1'b0, 100,      2'd1, 1'b1},
            '{1'b1, 2'd1, 20'd30,    1'b1, 1'b0, 1'b0, 70,       2'd1, 1'b1},
            '{1'b1, 2'd1, 20'd30,    1'b1, 1'b0, 1'b0, 40,       2'd1, 1'b1},
            '{1'b1, 2'd0, 20'd0,     1'b0, 1'b0, 1'b0, -3,       2'd0, 1'b1},
            '{1'b1, 2'd0, 20'd5,     1'b0, 1'b0, 1'b1, 0,        2'd0, 1'b1},
            '{1'b1, 2'd1, 20'd0,     1'b0, 1'b0, 1'b1, 0,        2'd1, 1'b1},
            '{1'b1, 2'd0, 20'd5,     1'b0, 1'b0, 1'b0, 5,        2'd0, 1'b1},
            '{1'b1, 2'd1, 20'd7,     1'b0, 1'b0, 1'b0, 7,        2'd1, 1'b1},
            '{1'b1, 2'd0, 20'd5,     1'b0, 1'b0, 1'b0, 10,       2'd0, 1'b1},
            '{1'b1, 2'd0, 20'd5,     1'b0, 1'b0, 1'b0, 15,       2'd0, 1'b1},
            '{1'b0, 2'd2, 20'd3,     1'b0, 1'b0, 1'b0, 15,       2'd0, 1'b0},
            '{1'b1, 2'd2, 20'd9,     1'b0, 1'b1, 1'b1, 0,        2'd2, 1'b1},
            '{1'b1, 2'd2, 20'd9,     1'b1, 1'b1, 1'b0, 9,        2'd2, 1'b1},
            '{1'b1, 2'd2, 20'h80000, 1'b1, 1'b0, 1'b0, 524297,   2'd2, 1'b1},
            '{1'b1, 2'd2, 20'd5,     1'b1, 1'b0, 1'b0, 524292,   2'd2, 1'b1},
            '{1'b1, 2'd1, 20'd0,     1'b0, 1'b0, 1'b0, 7,        2'd1, 1'b1},
            '{1'b1, 2'd3, 20'd0,     1'b0, 1'b0, 1'b0, 0,        2'd3, 1'b1},
            '{1'b1, 2'd3, 20'h80000, 1'b0, 1'b0, 1'b0, -524288,  2'd3, 1'b1},
            '{1'b0, 2'd1, 20'd1,     1'b0, 1'b0, 1'b0, -524288,  2'd3, 1'b0},
            '{1'b1, 2'd3, 20'h7FFFF, 1'b0, 1'b1, 1'b0, 524287,   2'd3, 1'b1}
        };

        reset = 1'b0;
        v1 = 0; ch1 = 0; a1 = 0; sub1 = 0; ld1 = 0; clr1 = 0;
        v2 = 0; ch2 = 0; a2 = 0; sub2 = 0; ld2 = 0; clr2 = 0;
        #12;
        check("reset P", longint'($signed(p1)), 0);
        check("reset valid_o", longint'(vo1), 0);
        check("reset ch_o", longint'(cho1), 0);
        if (Sat) check("reset ovf_o", longint'(ovf1), 0);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive1(vecs[i].v, vecs[i].ch, vecs[i].a, vecs[i].sub, vecs[i].ld, vecs[i].clr);
            check($sformatf("vec%0d P", i), longint'($signed(p1)), vecs[i].ep);
            check($sformatf("vec%0d ch_o", i), longint'(cho1), longint'(vecs[i].ech));
            check($sformatf("vec%0d valid_o", i), longint'(vo1), longint'(vecs[i].ev));
            if (Sat) check($sformatf("vec%0d ovf_o", i), longint'(ovf1), 0);
        end

        // Reset asserted mid-cycle with an update pending; outputs clear at once.
        v1 = 1; ch1 = 0; a1 = 20'd5; sub1 = 0; ld1 = 0; clr1 = 0;
        #3;
        reset = 1'b0;
        #1;
        check("async reset P", longint'($signed(p1)), 0);
        check("async reset valid_o", longint'(vo1), 0);
        @(posedge clk);
        #1;
        check("held reset valid_o", longint'(vo1), 0);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive1(1'b1, 2'(c), 20'd0, 1'b0, 1'b0, 1'b0);
            check($sformatf("post-reset ch%0d P", c), longint'($signed(p1)), 0);
            check($sformatf("post-reset ch%0d ch_o", c), longint'(cho1), longint'(c));
            check($sformatf("post-reset ch%0d valid_o", c), longint'(vo1), 1);
        end

        // Random run against the model; accumulators are all zero here.
        for (int c = 0; c < 4; c++) macc[c] = 0;
        p_m = 0; ch_m = 3; v_m = 1; ovf_m = 0;
        for (int n = 0; n < 1000; n++) begin
            logic        rv, rs, rl, rc;
            logic [1:0]  rch;
            logic [19:0] ra;
            int unsigned op;
            rv  = ($urandom % 4) != 0;
            rch = 2'($urandom);
            ra  = 20'($urandom);
            op  = $urandom % 8;
            rc  = (op == 0);
            rl  = (op == 1) || (op == 2 && ($urandom % 2) == 1);
            rs  = 1'($urandom);
            drive1(rv, rch, ra, rs, rl, rc);
            if (rv) begin
                macc[rch] = model_upd(macc[rch], longint'($signed(ra)), rs, rl, rc, 38, o);
                p_m = macc[rch]; ch_m = longint'(rch); v_m = 1; ovf_m = o;
            end else begin
                v_m = 0; ovf_m = 0;
            end
            check($sformatf("rand%0d P", n), longint'($signed(p1)), p_m);
            check($sformatf("rand%0d ch_o", n), longint'(cho1), ch_m);
            check($sformatf("rand%0d valid_o", n), longint'(vo1), longint'(v_m));
            if (Sat) check($sformatf("rand%0d ovf_o", n), longint'(ovf1), longint'(ovf_m));
        end
        v1 = 0;

        // Positive overflow on ch3 of the wide instance.
        step2("w ld", 1, 3, 36'h7_FFFF_FFFF, 0, 1, 0, 64'sd34359738367, 3, 1, 0);
        step2("w add1", 1, 3, 36'h7_FFFF_FFFF, 0, 0, 0, 64'sd68719476734, 3, 1, 0);
        step2("w add2", 1, 3, 36'h7_FFFF_FFFF, 0, 0, 0, 64'sd103079215101, 3, 1, 0);
        step2("w add3", 1, 3, 36'h7_FFFF_FFFF, 0, 0, 0, 64'sd137438953468, 3, 1, 0);
        step2("w max", 1, 3, 36'd3, 0, 0, 0, 64'sd137438953471, 3, 1, 0);
        step2("w ovf+", 1, 3, 36'd1, 0, 0, 0,
              Sat ? 64'sd137438953471 : -64'sd137438953472, 3, 1, Sat);
        step2("w after ovf+", 1, 3, 36'd0, 0, 0, 0,
              Sat ? 64'sd137438953471 : -64'sd137438953472, 3, 1, 0);
        // Out-of-range channel is dropped; P and ch_o hold.
        step2("w ch5 ignored", 1, 5, 36'd7, 0, 0, 0,
              Sat ? 64'sd137438953471 : -64'sd137438953472, 3, 0, 0);
        step2("w ch4", 1, 4, 36'd7, 0, 0, 0, 7, 4, 1, 0);
        // Negative overflow on ch2.
        step2("w ld neg", 1, 2, 36'h8_0000_0000, 0, 1, 0, -64'sd34359738368, 2, 1, 0);
        step2("w sub1", 1, 2, 36'h7_FFFF_FFFF, 1, 0, 0, -64'sd68719476735, 2, 1, 0);
        step2("w sub2", 1, 2, 36'h7_FFFF_FFFF, 1, 0, 0, -64'sd103079215102, 2, 1, 0);
        step2("w sub3", 1, 2, 36'h7_FFFF_FFFF, 1, 0, 0, -64'sd137438953469, 2, 1, 0);
        step2("w ovf-", 1, 2, 36'd4, 1, 0, 0,
              Sat ? -64'sd137438953472 : 64'sd137438953471, 2, 1, Sat);
        step2("w clr no ovf", 1, 2, 36'd4, 1, 0, 1, 0, 2, 1, 0);
        step2("w ch3 intact", 1, 3, 36'd0, 0, 0, 0,
              Sat ? 64'sd137438953471 : -64'sd137438953472, 3, 1, 0);
        step2("w idle", 0, 0, 36'd0, 0, 0, 0,
              Sat ? 64'sd137438953471 : -64'sd137438953472, 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
